// File: rtl/pipe_stage_chain_pkg.sv
// rtl/pipe_stage_chain_pkg.sv - shared CPU pipeline definitions: control bit positions, rd width, payload offsets
package pipe_stage_chain_pkg;

    localparam int CTRL_MEMREAD  = 0;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_REGWRITE = 2;
    localparam int CTRL_MEMTOREG = 3;
    localparam int PIPE_CTRL_W   = 4;
    localparam int PIPE_RD_W     = 5;
    localparam int PIPE_DATA_W   = 96;

    typedef enum logic [1:0] {
        BND_IF_ID  = 2'd0,
        BND_ID_EX  = 2'd1,
        BND_EX_MEM = 2'd2,
        BND_MEM_WB = 2'd3
    } boundary_t;

    // Payload field LSBs within data, one group per pipeline boundary; fields are 32 bits wide
    localparam int IFID_PC_LSB     = 0;
    localparam int IFID_INSTR_LSB  = 32;
    localparam int IDEX_PC_LSB     = 0;
    localparam int IDEX_RS1_LSB    = 32;
    localparam int IDEX_RS2_LSB    = 64;
    localparam int EXMEM_ALU_LSB   = 0;
    localparam int EXMEM_STORE_LSB = 32;
    localparam int EXMEM_PC_LSB    = 64;
    localparam int MEMWB_ALU_LSB   = 0;
    localparam int MEMWB_LOAD_LSB  = 32;
    localparam int MEMWB_PC_LSB    = 64;
    localparam int FIELD_W         = 32;

endpackage

// File: rtl/pipe_stage_chain_if.sv
// rtl/pipe_stage_chain_if.sv - pipeline chain bus: input payload, stall/flush controls, outputs and hazard taps
interface pipe_stage_chain_if #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 4,
    parameter int RD_W   = 5,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
);
    logic                    stall_i;
    logic [DEPTH-1:0]        flush_i;
    logic                    valid_i;
    logic [DATA_W-1:0]       data_i;
    logic [CTRL_W-1:0]       ctrl_i;
    logic [RD_W-1:0]         rd_i;
    logic                    cnt_clr_i;
    logic                    valid_o;
    logic [DATA_W-1:0]       data_o;
    logic [CTRL_W-1:0]       ctrl_o;
    logic [RD_W-1:0]         rd_o;
    logic [DEPTH-1:0]        stage_valid_o;
    logic [DEPTH*RD_W-1:0]   stage_rd_o;
    logic [DEPTH-1:0]        stage_wr_o;
    logic [CNT_W-1:0]        stall_cnt_o;

    modport slave (
        input  stall_i, flush_i, valid_i, data_i, ctrl_i, rd_i, cnt_clr_i,
        output valid_o, data_o, ctrl_o, rd_o, stage_valid_o, stage_rd_o, stage_wr_o, stall_cnt_o
    );

    modport master (
        output stall_i, flush_i, valid_i, data_i, ctrl_i, rd_i, cnt_clr_i,
        input  valid_o, data_o, ctrl_o, rd_o, stage_valid_o, stage_rd_o, stage_wr_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_stage_chain_reg.sv
// rtl/pipe_stage_chain_reg.sv - one pipeline stage register with hold and flush-to-bubble
module pipe_stage_chain_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 4,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [RD_W-1:0]   in_rd,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl,
    output logic [RD_W-1:0]   rd
);

    // Flush only kills valid/ctrl; data and rd follow normal hold/shift so they never go X
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
            rd    <= '0;
        end else begin
            if (!hold) begin
                data <= in_data;
                rd   <= in_rd;
            end
            if (flush) begin
                valid <= 1'b0;
                ctrl  <= '0;
            end else if (!hold) begin
                valid <= in_valid;
                ctrl  <= in_ctrl;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - parametrised pipeline register chain with stall, per-stage flush, hazard taps and stall counter
module pipe_stage_chain
    import pipe_stage_chain_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int RD_W   = PIPE_RD_W,
    parameter int DEPTH  = 1,
    parameter int WR_BIT = CTRL_REGWRITE,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    pipe_stage_chain_if.slave bus
);

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
            $fatal(1, "pipe_stage_chain: DEPTH must be in 1..4");
        end
        if (WR_BIT >= CTRL_W) begin : g_bad_wr_bit
            $fatal(1, "pipe_stage_chain: WR_BIT must be below CTRL_W");
        end
    endgenerate

    logic              stg_valid [DEPTH];
    logic [DATA_W-1:0] stg_data  [DEPTH];
    logic [CTRL_W-1:0] stg_ctrl  [DEPTH];
    logic [RD_W-1:0]   stg_rd    [DEPTH];
    logic [CNT_W-1:0]  stall_cnt;

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_stage
            logic              in_valid;
            logic [DATA_W-1:0] in_data;
            logic [CTRL_W-1:0] in_ctrl;
            logic [RD_W-1:0]   in_rd;

            if (k == 0) begin : g_head
                // Incoming ctrl is masked so a bubble can never carry write enables
                assign in_valid = bus.valid_i;
                assign in_data  = bus.data_i;
                assign in_ctrl  = bus.valid_i ? bus.ctrl_i : '0;
                assign in_rd    = bus.rd_i;
            end else begin : g_link
                assign in_valid = stg_valid[k-1];
                assign in_data  = stg_data[k-1];
                assign in_ctrl  = stg_ctrl[k-1];
                assign in_rd    = stg_rd[k-1];
            end

            pipe_stage_chain_reg #(
                .DATA_W(DATA_W),
                .CTRL_W(CTRL_W),
                .RD_W  (RD_W)
            ) u_stage (
                .clk     (clk_i),
                .rst     (rst_i),
                .hold    (bus.stall_i),
                .flush   (bus.flush_i[k]),
                .in_valid(in_valid),
                .in_data (in_data),
                .in_ctrl (in_ctrl),
                .in_rd   (in_rd),
                .valid   (stg_valid[k]),
                .data    (stg_data[k]),
                .ctrl    (stg_ctrl[k]),
                .rd      (stg_rd[k])
            );

            assign bus.stage_valid_o[k]              = stg_valid[k];
            assign bus.stage_rd_o[k*RD_W +: RD_W]    = stg_rd[k];
            assign bus.stage_wr_o[k]                 = stg_valid[k] & stg_ctrl[k][WR_BIT];
        end
    endgenerate

    assign bus.valid_o     = stg_valid[DEPTH-1];
    assign bus.data_o      = stg_data[DEPTH-1];
    assign bus.ctrl_o      = stg_ctrl[DEPTH-1];
    assign bus.rd_o        = stg_rd[DEPTH-1];
    assign bus.stall_cnt_o = stall_cnt;

    // Counts cycles where a valid instruction at the tail is being held back
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (bus.cnt_clr_i) begin
            stall_cnt <= '0;
        end else if (bus.stall_i && stg_valid[DEPTH-1] && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb/tb_pipe_stage_chain.sv - directed table-driven bench for pipe_stage_chain (DEPTH=2, CNT_W=4)
module tb_pipe_stage_chain;

    localparam int DATA_W = 96;
    localparam int CTRL_W = 4;
    localparam int RD_W   = 5;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = 4;
    localparam int NVEC   = 19;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    pipe_stage_chain_if #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .RD_W(RD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) bus ();

    pipe_stage_chain #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .RD_W(RD_W), .DEPTH(DEPTH), .WR_BIT(2), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              stall;
        logic [1:0]        flush;
        logic              vin;
        logic [DATA_W-1:0] din;
        logic [3:0]        cin;
        logic [4:0]        rin;
        logic              clr;
        logic              ev;
        logic [DATA_W-1:0] ed;
        logic [3:0]        ec;
        logic [4:0]        erd;
        logic [1:0]        esv;
        logic [1:0]        esw;
        logic [9:0]        esrd;
        logic [3:0]        ecnt;
    } vec_t;

    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic stall, input logic [1:0] flush, input logic vin,
                                input int din, input logic [3:0] cin, input int rin, input logic clr,
                                input logic ev, input int ed, input logic [3:0] ec, input int erd,
                                input logic [1:0] esv, input logic [1:0] esw, input int srd1,
                                input int srd0, input int ecnt);
        vec_t v;
        v.stall = stall;  v.flush = flush;  v.vin = vin;
        v.din   = DATA_W'(din);  v.cin = cin;  v.rin = 5'(rin);  v.clr = clr;
        v.ev    = ev;  v.ed = DATA_W'(ed);  v.ec = ec;  v.erd = 5'(erd);
        v.esv   = esv;  v.esw = esw;  v.esrd = {5'(srd1), 5'(srd0)};  v.ecnt = 4'(ecnt);
        return v;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic stall, input logic [1:0] flush, input logic vin,
                         input logic [DATA_W-1:0] din, input logic [3:0] cin,
                         input logic [4:0] rin, input logic clr);
        bus.stall_i   = stall;
        bus.flush_i   = flush;
        bus.valid_i   = vin;
        bus.data_i    = din;
        bus.ctrl_i    = cin;
        bus.rd_i      = rin;
        bus.cnt_clr_i = clr;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst     = 1'b1;
        drive(0, 2'b00, 0, '0, 4'h0, 5'd0, 0);

        //             st fl    v  d   c     rd clr | v d   c     rd sv     sw     srd1 srd0 cnt
        tbl[0]  = mk(0, 2'b00, 1, 1,  4'h4, 1, 0,   0, 0,  4'h0, 0, 2'b01, 2'b01, 0,  1,  0);
        tbl[1]  = mk(0, 2'b00, 1, 2,  4'h4, 2, 0,   1, 1,  4'h4, 1, 2'b11, 2'b11, 1,  2,  0);
        tbl[2]  = mk(0, 2'b00, 1, 3,  4'h4, 3, 0,   1, 2,  4'h4, 2, 2'b11, 2'b11, 2,  3,  0);
        tbl[3]  = mk(0, 2'b00, 1, 5,  4'h4, 5, 0,   1, 3,  4'h4, 3, 2'b11, 2'b11, 3,  5,  0);
        tbl[4]  = mk(0, 2'b00, 1, 6,  4'h4, 6, 0,   1, 5,  4'h4, 5, 2'b11, 2'b11, 5,  6,  0);
        tbl[5]  = mk(1, 2'b00, 1, 7,  4'h4, 7, 0,   1, 5,  4'h4, 5, 2'b11, 2'b11, 5,  6,  1);
        tbl[6]  = mk(1, 2'b00, 1, 7,  4'h4, 7, 0,   1, 5,  4'h4, 5, 2'b11, 2'b11, 5,  6,  2);
        tbl[7]  = mk(1, 2'b00, 1, 7,  4'h4, 7, 0,   1, 5,  4'h4, 5, 2'b11, 2'b11, 5,  6,  3);
        tbl[8]  = mk(0, 2'b00, 1, 7,  4'h4, 7, 0,   1, 6,  4'h4, 6, 2'b11, 2'b11, 6,  7,  3);
        tbl[9]  = mk(1, 2'b10, 1, 8,  4'h4, 8, 0,   0, 6,  4'h0, 6, 2'b01, 2'b01, 6,  7,  4);
        tbl[10] = mk(1, 2'b00, 1, 8,  4'h4, 8, 0,   0, 6,  4'h0, 6, 2'b01, 2'b01, 6,  7,  4);
        tbl[11] = mk(1, 2'b00, 1, 8,  4'h4, 8, 0,   0, 6,  4'h0, 6, 2'b01, 2'b01, 6,  7,  4);
        tbl[12] = mk(0, 2'b00, 1, 8,  4'h4, 8, 0,   1, 7,  4'h4, 7, 2'b11, 2'b11, 7,  8,  4);
        tbl[13] = mk(0, 2'b01, 1, 9,  4'hF, 9, 0,   1, 8,  4'h4, 8, 2'b10, 2'b10, 8,  9,  4);
        tbl[14] = mk(0, 2'b00, 0, 0,  4'h0, 0, 0,   0, 9,  4'h0, 9, 2'b00, 2'b00, 9,  0,  4);
        tbl[15] = mk(0, 2'b00, 1, 10, 4'hB, 10, 0,  0, 0,  4'h0, 0, 2'b01, 2'b00, 0,  10, 4);
        tbl[16] = mk(0, 2'b00, 0, 11, 4'hF, 11, 0,  1, 10, 4'hB, 10, 2'b10, 2'b00, 10, 11, 4);
        tbl[17] = mk(0, 2'b00, 0, 12, 4'hF, 12, 0,  0, 11, 4'h0, 11, 2'b00, 2'b00, 11, 12, 4);
        tbl[18] = mk(0, 2'b00, 0, 0,  4'h0, 0, 1,   0, 12, 4'h0, 12, 2'b00, 2'b00, 12, 0,  0);

        // Asynchronous reset while a valid item sits at the tail
        #12 rst = 1'b0;
        drive(0, 2'b00, 1, 96'hAA, 4'h4, 5'd3, 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        check("pre_reset_valid", 128'(bus.valid_o), 128'(1'b1));
        check("pre_reset_data", 128'(bus.data_o), 128'(96'hAA));
        rst = 1'b1;
        #1;
        check("async_rst_valid", 128'(bus.valid_o), 128'(1'b0));
        check("async_rst_data", 128'(bus.data_o), 128'(0));
        check("async_rst_ctrl", 128'(bus.ctrl_o), 128'(0));
        check("async_rst_rd", 128'(bus.rd_o), 128'(0));
        check("async_rst_stage_valid", 128'(bus.stage_valid_o), 128'(0));
        check("async_rst_stall_cnt", 128'(bus.stall_cnt_o), 128'(0));
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("post_release_valid", 128'(bus.stage_valid_o), 128'(0));
        check("post_release_rd", 128'(bus.stage_rd_o), 128'(0));
        tick();
        check("first_edge_stage_valid", 128'(bus.stage_valid_o), 128'(2'b01));
        check("first_edge_stage_rd", 128'(bus.stage_rd_o), 128'({5'd0, 5'd3}));

        // Clean state for the vector table
        drive(0, 2'b00, 0, '0, 4'h0, 5'd0, 0);
        rst = 1'b1;
        #3 rst = 1'b0;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].stall, tbl[i].flush, tbl[i].vin, tbl[i].din, tbl[i].cin, tbl[i].rin, tbl[i].clr);
            tick();
            check($sformatf("vec%0d valid_o", i), 128'(bus.valid_o), 128'(tbl[i].ev));
            check($sformatf("vec%0d data_o", i), 128'(bus.data_o), 128'(tbl[i].ed));
            check($sformatf("vec%0d ctrl_o", i), 128'(bus.ctrl_o), 128'(tbl[i].ec));
            check($sformatf("vec%0d rd_o", i), 128'(bus.rd_o), 128'(tbl[i].erd));
            check($sformatf("vec%0d stage_valid", i), 128'(bus.stage_valid_o), 128'(tbl[i].esv));
            check($sformatf("vec%0d stage_wr", i), 128'(bus.stage_wr_o), 128'(tbl[i].esw));
            check($sformatf("vec%0d stage_rd", i), 128'(bus.stage_rd_o), 128'(tbl[i].esrd));
            check($sformatf("vec%0d stall_cnt", i), 128'(bus.stall_cnt_o), 128'(tbl[i].ecnt));
        end

        // Saturation of the 4-bit stall counter, then clear beating increment
        drive(0, 2'b00, 1, 96'd13, 4'h4, 5'd13, 0);
        tick();
        tick();
        check("sat_setup_valid", 128'(bus.valid_o), 128'(1'b1));
        check("sat_setup_cnt", 128'(bus.stall_cnt_o), 128'(0));
        drive(1, 2'b00, 1, 96'd14, 4'h4, 5'd14, 0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) check("cnt_at_14", 128'(bus.stall_cnt_o), 128'(14));
            if (i == 15) check("cnt_at_15", 128'(bus.stall_cnt_o), 128'(15));
            if (i == 20) check("cnt_saturated", 128'(bus.stall_cnt_o), 128'(15));
        end
        check("sat_data_held", 128'(bus.data_o), 128'(13));
        bus.cnt_clr_i = 1'b1;
        tick();
        check("cnt_clear_over_inc", 128'(bus.stall_cnt_o), 128'(0));
        bus.cnt_clr_i = 1'b0;
        tick();
        check("cnt_resume", 128'(bus.stall_cnt_o), 128'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
